ltc2174_capture: RTL and testbench

Downstream consumer of the LTC2174 one-bank receiver: takes the four deserialized 16-bit ADC channels and the 16-bit frame word on the ADC divided clock, and checks frame alignment continuously. On an armed trigger it captures a fixed-length burst of all four channels into an on-chip buffer, which the host reads back through a simple address/data port. It sits between the ISERDES receiver and the host register/readout logic, and gives software both a frame-lock health indicator and waveform snapshots.

---
 rtl/ltc2174_pkg.sv | 10 +
 rtl/ltc2174_capture_if.sv | 9 +
 rtl/ltc2174_cap_ram.sv | 19 +
 rtl/ltc2174_capture.sv | 107 ++++++++++
 tb/tb_ltc2174_capture.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ltc2174_pkg.sv
// ltc2174_pkg: shared types and constants for the LTC2174 capture block
package ltc2174_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;
  localparam logic [15:0] FRAME_PATTERN_DEF = 16'hFF00;
  localparam int CH_W = 16;
  localparam int SAMPLE_W = 4 * CH_W;
  function automatic logic [SAMPLE_W-1:0] pack_sample(input logic [CH_W-1:0] a1, a2, a3, a4);
    return {a4, a3, a2, a1};
  endfunction
endpackage

// File: rtl/ltc2174_capture_if.sv
// ltc2174_capture_if: host readout port (rd_addr from host, rd_data back with 1-cycle latency)
//   master: host side, drives rd_addr
//   slave:  capture block side, drives rd_data
interface ltc2174_capture_if import ltc2174_pkg::*; #(parameter int DEPTH_LOG2 = 10);
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [SAMPLE_W-1:0] rd_data;
  modport master(output rd_addr, input rd_data);
  modport slave(input rd_addr, output rd_data);
endinterface

// File: rtl/ltc2174_cap_ram.sv
// ltc2174_cap_ram: simple dual-port RAM, one write port, registered read port, no reset
//   clk, we/wa/wd write port, ra read address, rd read data (old data on same-address collision)
module ltc2174_cap_ram #(
  parameter int AW = 10,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end
endmodule

// File: rtl/ltc2174_capture.sv
// ltc2174_capture: frame-alignment monitor and triggered 4-channel burst capture for the LTC2174
//   clk/reset_n (async active-low), adc1..adc4/frame deserialized inputs, arm/trig/abort/err_clr
//   controls, thresh self-trigger level, rd readout interface (slave), state/done/wr_count/
//   capture_clean status, frame_lock/frame_err_cnt frame health.
//   Optional LTC2174_SELF_TRIG_EN: adc1 upward crossing of thresh also triggers in ARMED.
module ltc2174_capture import ltc2174_pkg::*; #(
  parameter int          DEPTH_LOG2    = 10,
  parameter logic [15:0] FRAME_PATTERN = FRAME_PATTERN_DEF,
  parameter int          LOCK_COUNT    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [15:0]           adc1,
  input  logic [15:0]           adc2,
  input  logic [15:0]           adc3,
  input  logic [15:0]           adc4,
  input  logic [15:0]           frame,
  input  logic                  arm,
  input  logic                  trig,
  input  logic                  abort,
  input  logic                  err_clr,
  input  logic [15:0]           thresh,
  ltc2174_capture_if.slave      rd,
  output logic [1:0]            state,
  output logic                  done,
  output logic [DEPTH_LOG2:0]   wr_count,
  output logic                  capture_clean,
  output logic                  frame_lock,
  output logic [15:0]           frame_err_cnt
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  state_t state_q, state_d;
  logic trig_q, trig_evt, match, last, wr_en, wr_en_q, rd_ok;
  logic [DEPTH_LOG2-1:0] wr_addr_q;
  logic [SAMPLE_W-1:0] sample_q, ram_q;
  logic [7:0] run_cnt;
  assign match = frame == FRAME_PATTERN;
  assign last = wr_count == (DEPTH_LOG2+1)'(DEPTH - 1);
  assign state = state_q;
  assign done = state_q == DONE;
`ifdef LTC2174_SELF_TRIG_EN
  logic [15:0] adc1_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) adc1_q <= '0;
    else adc1_q <= adc1;
  assign trig_evt = (trig & ~trig_q) | ($signed(adc1_q) < $signed(thresh) && $signed(adc1) >= $signed(thresh));
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh;
  assign trig_evt = trig & ~trig_q;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    wr_en = 1'b0;
    case (state_q)
      IDLE:    state_d = arm ? ARMED : IDLE;
      ARMED:   begin wr_en = trig_evt; state_d = trig_evt ? CAPTURE : ARMED; end
      CAPTURE: begin wr_en = 1'b1; state_d = last ? DONE : CAPTURE; end
      default: state_d = arm ? ARMED : DONE;
    endcase
    if (abort) begin
      state_d = IDLE;
      wr_en = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      trig_q <= 1'b0;
      wr_en_q <= 1'b0;
      wr_count <= '0;
      capture_clean <= 1'b0;
      run_cnt <= '0;
      frame_lock <= 1'b0;
      frame_err_cnt <= '0;
      rd_ok <= 1'b0;
    end else begin
      trig_q <= trig;
      wr_en_q <= wr_en;
      rd_ok <= 1'b1;
      if (state_d == ARMED && state_q != ARMED) wr_count <= '0;
      else if (wr_en) wr_count <= wr_count + (DEPTH_LOG2+1)'(1);
      // the trigger-cycle sample counts toward cleanliness, so arm-time value is the match itself
      if (wr_en && state_q == ARMED) capture_clean <= match;
      else if (wr_en && !match) capture_clean <= 1'b0;
      run_cnt <= !match ? '0 : run_cnt == 8'(LOCK_COUNT) ? run_cnt : run_cnt + 8'd1;
      frame_lock <= match && (frame_lock || run_cnt + 8'd1 == 8'(LOCK_COUNT));
      frame_err_cnt <= err_clr ? '0 : (!match && frame_err_cnt != '1) ? frame_err_cnt + 16'd1 : frame_err_cnt;
    end
  // one register stage between the inputs and the RAM write port
  always_ff @(posedge clk) begin
    sample_q <= pack_sample(adc1, adc2, adc3, adc4);
    wr_addr_q <= wr_count[DEPTH_LOG2-1:0];
  end
  ltc2174_cap_ram #(.AW(DEPTH_LOG2), .DW(SAMPLE_W)) u_ram (
    .clk(clk),
    .we(wr_en_q),
    .wa(wr_addr_q),
    .wd(sample_q),
    .ra(rd.rd_addr),
    .rd(ram_q)
  );
  // RAM has no reset; mask its output until the first post-reset read has completed
  assign rd.rd_data = rd_ok ? ram_q : '0;
endmodule

// File: tb/tb_ltc2174_capture.sv
// tb_ltc2174_capture: directed self-checking bench for ltc2174_capture (DEPTH_LOG2=4)
module tb_ltc2174_capture;
  import ltc2174_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [15:0] adc1 = 16'd0, adc2 = 16'h1111, adc3 = 16'h2222, adc4 = 16'h3333;
  logic [15:0] frame = 16'hFF00, thresh = 16'h0000;
  logic arm = 1'b0, trig = 1'b0, abort = 1'b0, err_clr = 1'b0;
  logic [1:0] state;
  logic done, capture_clean, frame_lock;
  logic [4:0] wr_count;
  logic [15:0] frame_err_cnt;
  int vectors = 0, errors = 0;
  ltc2174_capture_if #(.DEPTH_LOG2(4)) rd_if();
  ltc2174_capture #(.DEPTH_LOG2(4), .FRAME_PATTERN(16'hFF00), .LOCK_COUNT(16)) dut (
    .clk(clk), .reset_n(reset_n), .adc1(adc1), .adc2(adc2), .adc3(adc3), .adc4(adc4),
    .frame(frame), .arm(arm), .trig(trig), .abort(abort), .err_clr(err_clr), .thresh(thresh),
    .rd(rd_if), .state(state), .done(done), .wr_count(wr_count), .capture_clean(capture_clean),
    .frame_lock(frame_lock), .frame_err_cnt(frame_err_cnt)
  );
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
  task automatic tick();
    @(posedge clk);
    #1;
    adc1 = adc1 + 16'd1;
  endtask
  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask
  task automatic pulse_trig();
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask
  task automatic test_reset();
    rd_if.rd_addr = '0;
    repeat (3) tick();
    vectors++;
    if ({state, done, wr_count, capture_clean, frame_lock, frame_err_cnt} !== 26'd0) begin
      errors++;
      $display("FAIL reset_status: got state=%0d done=%b wr_count=%0d clean=%b lock=%b err=%0d, want all 0", state, done, wr_count, capture_clean, frame_lock, frame_err_cnt);
    end
    vectors++;
    if (rd_if.rd_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_rd_data: got %h want 0", rd_if.rd_data);
    end
    reset_n = 1'b1;
  endtask
  task automatic test_frame_lock();
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) begin
        vectors++;
        if (frame_lock !== 1'b0) begin errors++; $display("FAIL lock_early: got %b want 0", frame_lock); end
      end
    end
    vectors++;
    if (frame_lock !== 1'b1) begin errors++; $display("FAIL lock_16: got %b want 1", frame_lock); end
    frame = 16'hFE01;
    tick();
    frame = 16'hFF00;
    vectors++;
    if (frame_lock !== 1'b0 || frame_err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL lock_drop: got lock=%b err=%0d want lock=0 err=1", frame_lock, frame_err_cnt);
    end
    repeat (15) tick();
    vectors++;
    if (frame_lock !== 1'b0) begin errors++; $display("FAIL relock_early: got %b want 0", frame_lock); end
    tick();
    vectors++;
    if (frame_lock !== 1'b1) begin errors++; $display("FAIL relock: got %b want 1", frame_lock); end
    frame = 16'hFE01;
    tick();
    vectors++;
    if (frame_err_cnt !== 16'd2) begin errors++; $display("FAIL err_cnt_2: got %0d want 2", frame_err_cnt); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    frame = 16'hFF00;
    vectors++;
    if (frame_err_cnt !== 16'd0) begin errors++; $display("FAIL err_clr_wins: got %0d want 0", frame_err_cnt); end
  endtask
  task automatic test_capture();
    adc1 = 16'd95;
    do_arm();
    vectors++;
    if (state !== 2'd1 || wr_count !== 5'd0) begin
      errors++;
      $display("FAIL arm: got state=%0d wr_count=%0d want 1/0", state, wr_count);
    end
    for (int i = 0; i < 10 && adc1 != 16'd100; i++) tick();
    pulse_trig();
    vectors++;
    if (state !== 2'd2 || wr_count !== 5'd1) begin
      errors++;
      $display("FAIL trig_start: got state=%0d wr_count=%0d want 2/1", state, wr_count);
    end
    repeat (14) tick();
    vectors++;
    if (state !== 2'd2 || done !== 1'b0) begin
      errors++;
      $display("FAIL capture_len: got state=%0d done=%b want 2/0", state, done);
    end
    tick();
    vectors++;
    if (state !== 2'd3 || done !== 1'b1 || wr_count !== 5'd16 || capture_clean !== 1'b1) begin
      errors++;
      $display("FAIL capture_done: got state=%0d done=%b wr_count=%0d clean=%b want 3/1/16/1", state, done, wr_count, capture_clean);
    end
    tick();
    rd_if.rd_addr = 4'd0;
    tick();
    vectors++;
    if (rd_if.rd_data !== 64'h3333_2222_1111_0064) begin
      errors++;
      $display("FAIL rd_addr0: got %h want 3333222211110064", rd_if.rd_data);
    end
    rd_if.rd_addr = 4'd15;
    tick();
    vectors++;
    if (rd_if.rd_data !== 64'h3333_2222_1111_0073) begin
      errors++;
      $display("FAIL rd_addr15: got %h want 3333222211110073", rd_if.rd_data);
    end
  endtask
  task automatic test_trig_held();
    trig = 1'b1;
    tick();
    do_arm();
    repeat (3) tick();
    vectors++;
    if (state !== 2'd1) begin errors++; $display("FAIL held_no_fire: got state=%0d want 1", state); end
    trig = 1'b0;
    tick();
    vectors++;
    if (state !== 2'd1) begin errors++; $display("FAIL held_fall: got state=%0d want 1", state); end
    pulse_trig();
    vectors++;
    if (state !== 2'd2) begin errors++; $display("FAIL held_rearm_fire: got state=%0d want 2", state); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if (state !== 2'd0 || wr_count !== 5'd1) begin
      errors++;
      $display("FAIL held_abort: got state=%0d wr_count=%0d want 0/1", state, wr_count);
    end
  endtask
  task automatic test_abort();
    logic [15:0] t0;
    do_arm();
    pulse_trig();
    repeat (4) tick();
    vectors++;
    if (wr_count !== 5'd5) begin errors++; $display("FAIL abort_pre: got wr_count=%0d want 5", wr_count); end
    abort = 1'b1;
    arm = 1'b1;
    tick();
    abort = 1'b0;
    arm = 1'b0;
    tick();
    vectors++;
    if (state !== 2'd0 || wr_count !== 5'd5) begin
      errors++;
      $display("FAIL abort_hold: got state=%0d wr_count=%0d want 0/5", state, wr_count);
    end
    do_arm();
    t0 = adc1;
    pulse_trig();
    repeat (15) tick();
    vectors++;
    if (state !== 2'd3 || wr_count !== 5'd16) begin
      errors++;
      $display("FAIL abort_recapture: got state=%0d wr_count=%0d want 3/16", state, wr_count);
    end
    tick();
    rd_if.rd_addr = 4'd15;
    tick();
    vectors++;
    if (rd_if.rd_data !== {48'h3333_2222_1111, t0 + 16'd15}) begin
      errors++;
      $display("FAIL abort_recapture_data: got %h want %h", rd_if.rd_data, {48'h3333_2222_1111, t0 + 16'd15});
    end
  endtask
  task automatic test_clean();
    do_arm();
    pulse_trig();
    repeat (2) tick();
    frame = 16'hFE01;
    tick();
    frame = 16'hFF00;
    repeat (12) tick();
    vectors++;
    if (state !== 2'd3 || capture_clean !== 1'b0) begin
      errors++;
      $display("FAIL dirty_capture: got state=%0d clean=%b want 3/0", state, capture_clean);
    end
    do_arm();
    pulse_trig();
    repeat (15) tick();
    vectors++;
    if (state !== 2'd3 || capture_clean !== 1'b1) begin
      errors++;
      $display("FAIL clean_capture: got state=%0d clean=%b want 3/1", state, capture_clean);
    end
  endtask
  task automatic test_self_trig();
    thresh = 16'h0040;
    adc1 = 16'h0030;
    do_arm();
`ifdef LTC2174_SELF_TRIG_EN
    for (int i = 0; i < 40 && state != 2'd2; i++) tick();
    vectors++;
    if (state !== 2'd2) begin errors++; $display("FAIL self_trig_start: got state=%0d want 2", state); end
    repeat (15) tick();
    tick();
    rd_if.rd_addr = 4'd0;
    tick();
    vectors++;
    if (rd_if.rd_data !== 64'h3333_2222_1111_0040) begin
      errors++;
      $display("FAIL self_trig_addr0: got %h want 3333222211110040", rd_if.rd_data);
    end
`else
    repeat (40) tick();
    vectors++;
    if (state !== 2'd1 || wr_count !== 5'd0) begin
      errors++;
      $display("FAIL self_trig_off: got state=%0d wr_count=%0d want 1/0", state, wr_count);
    end
`endif
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask
  initial begin
    test_reset();
    test_frame_lock();
    test_capture();
    test_trig_held();
    test_abort();
    test_clean();
    test_self_trig();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
